mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory-access stage plus MEM/WB pipeline register, directly downstream of the EX/MEM latch.
//  Consumes EX/MEM outputs and issues the data-cache request through a small FSM.
//  Stalls upstream until dhit, selects write-back data and registers the WB fields.
//  Provides sticky halt and a request-timeout error flag.
// PARAMETERS
//  WORD_W      32   data/address width
//  TIMEOUT_CYC 256  REQ cycles without dhit before err_timeout is set (>=1)
//  CNT_W       9    timeout counter width; must hold TIMEOUT_CYC
// PORTS
//  CLK          in   1       clock, rising edge
//  RST          in   1       synchronous, active-high reset
//  ex_valid     in   1       EX/MEM holds a real instruction
//  ex_dREN      in   1       load request
//  ex_dWEN      in   1       store request (ex_dREN & ex_dWEN both 1 is illegal)
//  ex_addr      in   WORD_W  ALU result / data address (portO)
//  ex_store     in   WORD_W  store data
//  ex_lui       in   WORD_W  LUI value
//  ex_pcp4      in   WORD_W  PC+4
//  ex_RegWr     in   1       register write enable
//  ex_MemToReg  in   2       WB select: 0 ALU, 1 load, 2 LUI, 3 PC+4
//  ex_wsel      in   5       destination register
//  ex_halt      in   1       halt instruction
//  dhit         in   1       cache done (load data valid / store committed)
//  dload        in   WORD_W  cache load data
//  dREN, dWEN   out  1       cache request strobes
//  daddr        out  WORD_W  cache address
//  dstore       out  WORD_W  cache store data
//  mem_busy     out  1       upstream stall: EX/MEM must hold its contents
//  wb_RegWr     out  1       registered register write enable
//  wb_wsel      out  5       registered destination register
//  wb_wdat      out  WORD_W  registered write-back data
//  wb_halt      out  1       sticky halt
//  err_timeout  out  1       sticky timeout error
// BEHAVIOUR
//  - Reset (RST high at edge): state IDLE, counter 0, all wb_* 0, wb_halt 0, err_timeout 0.
//    Combinational outputs are 0 in the cycle after the reset edge. Reset mid-REQ drops dREN/dWEN.
//  - memop = ex_valid & (ex_dREN | ex_dWEN) & !wb_halt.
//  - IDLE:
//    - memop: mem_busy=1 (comb), next state REQ, and WB loads a bubble (wb_RegWr=0).
//    - ex_valid & !memop & !wb_halt: WB loads the instruction at next edge (latency 1).
//    - !ex_valid: WB loads a bubble.
//  - REQ:
//    - dREN=ex_dREN, dWEN=ex_dWEN, daddr=ex_addr, dstore=ex_store. EX/MEM is held stable by mem_busy.
//    - No dhit: mem_busy=1, counter+1 (saturates), WB holds a bubble.
//    - dhit: mem_busy=0 (upstream advances this edge), WB captures instruction with
//      dload selected if MemToReg=1, state->IDLE, counter cleared. Load latency = dhit cycle + 1.
//    - counter reaching TIMEOUT_CYC sets err_timeout (sticky); FSM keeps waiting.
//  - Outside REQ: dREN=dWEN=0, daddr=ex_addr, dstore=ex_store.
//  - wb_wdat mux by MemToReg (0 ex_addr, 1 dload, 2 ex_lui, 3 ex_pcp4); width WORD_W, no extension.
//  - wb_RegWr = ex_RegWr & (ex_wsel!=0) when captured; else 0 (writes to $0 squashed).
//  - Halt: ex_valid & ex_halt & !mem_busy sets wb_halt (sticky until RST).
//    After that, all input is ignored: bubbles only, no new requests.
//  - dhit seen in IDLE is ignored. Simultaneous dhit and timeout terminal count: dhit wins, no error.
// TESTING
//  - ALU op: ex_valid=1, MemToReg=0, addr=0x10, wsel=3, RegWr=1 -> next edge wb_wdat=0x10, wb_wsel=3, wb_RegWr=1, mem_busy=0.
//  - Load, dhit 3 cycles after REQ entry with dload=0xCAFEF00D -> mem_busy high 4 cycles,
//    dREN=1 in REQ, wb_wdat=0xCAFEF00D one edge after dhit.
//  - Store addr=0x40, data=0x55 -> dWEN=1, daddr=0x40, dstore=0x55 in REQ; on dhit wb_RegWr=0, state IDLE.
//  - wsel=0 with RegWr=1 -> wb_RegWr=0. LUI (MemToReg=2, lui=0xABCD0000) -> wb_wdat=0xABCD0000.
//  - Halt then load -> wb_halt=1 and stays 1; dREN never asserted; mem_busy=0.
//  - TIMEOUT_CYC=4, no dhit -> err_timeout=1 after 4 REQ cycles.
//    Then RST mid-REQ -> next cycle dREN=0, err_timeout=0, state IDLE.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Bundle of EX/MEM inputs, data-cache request/response and MEM/WB outputs.
// slave is the stage's view; master is the view of whatever drives EX/MEM and the cache.
interface mem_wb_stage_if #(
  parameter int unsigned WORD_W = 32
);
  logic              ex_valid;
  logic              ex_dREN;
  logic              ex_dWEN;
  logic [WORD_W-1:0] ex_addr;
  logic [WORD_W-1:0] ex_store;
  logic [WORD_W-1:0] ex_lui;
  logic [WORD_W-1:0] ex_pcp4;
  logic              ex_RegWr;
  logic [1:0]        ex_MemToReg;
  logic [4:0]        ex_wsel;
  logic              ex_halt;
  logic              dhit;
  logic [WORD_W-1:0] dload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              mem_busy;
  logic              wb_RegWr;
  logic [4:0]        wb_wsel;
  logic [WORD_W-1:0] wb_wdat;
  logic              wb_halt;
  logic              err_timeout;

  modport slave (
    input  ex_valid, ex_dREN, ex_dWEN, ex_addr, ex_store, ex_lui, ex_pcp4,
    input  ex_RegWr, ex_MemToReg, ex_wsel, ex_halt, dhit, dload,
    output dREN, dWEN, daddr, dstore, mem_busy,
    output wb_RegWr, wb_wsel, wb_wdat, wb_halt, err_timeout
  );

  modport master (
    output ex_valid, ex_dREN, ex_dWEN, ex_addr, ex_store, ex_lui, ex_pcp4,
    output ex_RegWr, ex_MemToReg, ex_wsel, ex_halt, dhit, dload,
    input  dREN, dWEN, daddr, dstore, mem_busy,
    input  wb_RegWr, wb_wsel, wb_wdat, wb_halt, err_timeout
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB register: issues one cache request per memory op,
// stalls EX/MEM until dhit, and keeps sticky halt and request-timeout flags.
module mem_wb_stage #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 9
) (
  input logic            CLK,
  input logic            RST,
  mem_wb_stage_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TIMEOUT_CYC);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              halt_q, halt_d;
  logic              wb_regwr_q;
  logic [4:0]        wb_wsel_q;
  logic [WORD_W-1:0] wb_wdat_q;
  logic              memop, capture, busy, dren, dwen;
  logic [WORD_W-1:0] wdat_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    capture = 1'b0;
    busy    = 1'b0;
    dren    = 1'b0;
    dwen    = 1'b0;
    memop   = bus.ex_valid & (bus.ex_dREN | bus.ex_dWEN) & ~halt_q;
    unique case (state_q)
      StIdle: begin
        if (memop) begin
          busy    = 1'b1;
          state_d = StReq;
        end else begin
          capture = bus.ex_valid & ~halt_q;
        end
      end
      StReq: begin
        dren = bus.ex_dREN;
        dwen = bus.ex_dWEN;
        if (bus.dhit) begin
          // A hit on the terminal-count cycle completes the access without an error.
          capture = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          busy = 1'b1;
          if (cnt_q != TermCnt) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TermCnt) err_d = 1'b1;
        end
      end
    endcase
    halt_d = halt_q | (bus.ex_valid & bus.ex_halt & ~busy);
  end

  always_comb begin
    unique case (bus.ex_MemToReg)
      2'd0: wdat_sel = bus.ex_addr;
      2'd1: wdat_sel = bus.dload;
      2'd2: wdat_sel = bus.ex_lui;
      2'd3: wdat_sel = bus.ex_pcp4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      halt_q     <= 1'b0;
      wb_regwr_q <= 1'b0;
      wb_wsel_q  <= '0;
      wb_wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      if (capture) begin
        wb_regwr_q <= bus.ex_RegWr & (bus.ex_wsel != 5'd0);
        wb_wsel_q  <= bus.ex_wsel;
        wb_wdat_q  <= wdat_sel;
      end else begin
        wb_regwr_q <= 1'b0;
      end
    end
  end

  assign bus.dREN        = dren;
  assign bus.dWEN        = dwen;
  assign bus.daddr       = bus.ex_addr;
  assign bus.dstore      = bus.ex_store;
  assign bus.mem_busy    = busy;
  assign bus.wb_RegWr    = wb_regwr_q;
  assign bus.wb_wsel     = wb_wsel_q;
  assign bus.wb_wdat     = wb_wdat_q;
  assign bus.wb_halt     = halt_q;
  assign bus.err_timeout = err_q;

endmodule
